commit_monitor: RTL and testbench
=================================

# commit_monitor

Synthesizable observation stage hanging off the single-cycle MIPS core's register-file write port. Every cycle it samples the core's PC and write-back signals. Each architectural register write (excluding `$zero`) is captured as a timestamped commit record in a small FIFO. Records drain through a valid/ready handshake to a downstream consumer such as a UART formatter or LED display. This gives on-board, cycle-accurate visibility of `$s0`–`$t3`-style state changes without simulator hierarchy peeking.

## Interface
Parameters:
- `DEPTH`, 8 — FIFO entries; power of two, ≥2.
- `CYCLE_W`, 16 — width of the cycle timestamp counter.

Ports:
- `clk`  in  1  — core clock; all state updates on rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `pc`  in  32  — PC of the instruction executing this cycle.
- `reg_write`  in  1  — register-file write enable from the core.
- `write_reg`  in  5  — destination register index.
- `write_data`  in  32  — value being written.
- `rec_ready`  in  1  — consumer accepts the head record.
- `rec_valid`  out  1  — head record present.
- `rec_pc`  out  32  — head record PC.
- `rec_reg`  out  5  — head record register index.
- `rec_data`  out  32  — head record data.
- `rec_cycle`  out  CYCLE_W  — head record timestamp.
- `fill`  out  log2(DEPTH)+1  — current occupancy.
- `overflow`  out  1  — sticky; set when any record was dropped.
- `drop_count`  out  8  — dropped records, saturating at 255.

## Operation
- Cycle counter: 0 after reset, +1 every cycle, wraps modulo 2^CYCLE_W. The stamp is the counter value in the capture cycle.
- Capture condition: `reg_write && write_reg != 0`. A capture forms a record {pc, write_reg, write_data, cycle}.
- Pop condition: `rec_valid && rec_ready`. `rec_ready` while empty is ignored.
- Push while not full: record written at tail; tail and fill advance.
- Push while full with no pop: record discarded; `overflow` set; `drop_count` += 1, saturating.
- Push and pop in the same cycle: both take effect and fill is unchanged. This includes the full case, where the push is accepted and nothing is dropped. In the empty case the push lands and the pop is not performed, because `rec_valid` was 0.
- Head outputs are first-word-fall-through: `rec_*` reflect the head entry whenever `rec_valid`=1. Values are undefined-but-stable while `rec_valid`=0.
- Pointers wrap modulo DEPTH.
- `overflow` and `drop_count` clear only on `rst`.

## Timing
- Reset values:
  - `rec_valid`=0, `fill`=0, `overflow`=0, `drop_count`=0.
  - Cycle counter=0.
  - `rec_pc`/`rec_reg`/`rec_data`/`rec_cycle`=0; storage is not required to clear.
- Capture latency: a write sampled at edge N gives `rec_valid`=1 (if the FIFO was empty) in the cycle after edge N.
- A record popped at edge N is gone after N; the next head, if any, is presented in the same cycle.
- Throughput: one push and one pop per cycle sustained.
- Handshake rules:
  - Once `rec_valid`=1, the head record holds until popped or `rst`.
  - `rec_valid` does not drop without a pop.
- `rst` mid-operation: asserted at edge N, all queued records are discarded, and outputs hold reset values from N until the first edge with `rst`=0. Captures during `rst` are ignored.
- No combinational path from `rec_ready` to any output other than through registered state.

## Structure
- Shared package `mips_pkg`:
  - `REG_ZERO` (5'd0) constant.
  - `commit_rec_t` packed struct {pc[31:0], rd[4:0], data[31:0]}, with the cycle field sized by the parameter at use.
- One sub-module: `sync_fifo` (parameterized width/depth, FWFT, push/pop/full/empty/fill).
- Top-level `commit_monitor` owns the capture filter, cycle counter, and drop/overflow logic.

## Test plan
- After reset, write `$s0`(16)=0x00000005 at PC 0x00000004 in cycle 3, with `rec_ready`=1 → next cycle: `rec_valid`=1, `rec_pc`=0x4, `rec_reg`=16, `rec_data`=0x5, `rec_cycle`=3; popped, `fill` returns to 0.
- `reg_write`=1 with `write_reg`=0 for 4 cycles → `rec_valid` stays 0, `fill`=0.
- `rec_ready`=0, 10 consecutive captures of `$t0`=1..10 with DEPTH=8 → `fill`=8, `overflow`=1, `drop_count`=2. Draining yields data 1..8 in order, with stamps consecutive.
- Full FIFO with simultaneous capture and pop → `fill` stays 8, `drop_count` unchanged, new record appears last in the drain order.
- 3 records queued, `rst` pulsed for 1 cycle → next cycle: `rec_valid`=0, `fill`=0, `overflow`=0, cycle counter restarts at 0.
- CYCLE_W=4, capture in cycles 15 and 16 → stamps 15 and 0 (wrap).

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and commit record type for the MIPS core observers
package mips_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Commit record body; the cycle stamp is appended at the use site
    // because its width is a parameter of the observer.
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
    } commit_rec_t;

    localparam int REC_W = $bits(commit_rec_t);

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO with occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_fill
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [FW-1:0]    r_fill;
    logic             w_pop;
    logic             w_push;

    // A pop on empty is ignored; a push on full is only taken when a pop frees the slot.
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_empty = (r_fill == '0);
    assign o_full  = (r_fill == FW'(DEPTH));
    assign o_fill  = r_fill;
    assign o_data  = r_mem[r_head];

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_fill <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + AW'(1);
            if (w_pop)  r_head <= r_head + AW'(1);
            r_fill <= r_fill + FW'(w_push) - FW'(w_pop);
        end
    end

    // Storage is not reset; the head is only meaningful while non-empty.
    always_ff @(posedge clk) begin
        if (!rst && w_push) r_mem[r_tail] <= i_data;
    end

endmodule

// File: rtl/commit_monitor.sv
// rtl/commit_monitor.sv - captures register-file writes as timestamped records into a drainable FIFO
module commit_monitor
    import mips_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int CYCLE_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              pc,
    input  logic                     reg_write,
    input  logic [4:0]               write_reg,
    input  logic [31:0]              write_data,
    input  logic                     rec_ready,
    output logic                     rec_valid,
    output logic [31:0]              rec_pc,
    output logic [4:0]               rec_reg,
    output logic [31:0]              rec_data,
    output logic [CYCLE_W-1:0]       rec_cycle,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     overflow,
    output logic [7:0]               drop_count
);

    localparam int FIFO_W = REC_W + CYCLE_W;

    logic [CYCLE_W-1:0] r_cycle;
    logic               r_overflow;
    logic [7:0]         r_drop_count;

    logic               w_capture;
    logic               w_full;
    logic               w_empty;
    logic               w_drop;
    commit_rec_t        w_rec;
    commit_rec_t        w_head_rec;
    logic [FIFO_W-1:0]  w_push_word;
    logic [FIFO_W-1:0]  w_head_word;

    assign w_capture   = reg_write && (write_reg != REG_ZERO);
    assign w_rec       = '{pc: pc, rd: write_reg, data: write_data};
    assign w_push_word = {w_rec, r_cycle};
    // Full implies a head is present, so a ready consumer always makes room.
    assign w_drop      = w_capture && w_full && !rec_ready;

    sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_capture),
        .i_pop   (rec_ready),
        .i_data  (w_push_word),
        .o_data  (w_head_word),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_fill  (fill)
    );

    // Head fields are forced to zero while empty so reset shows clean outputs
    // without having to clear the storage array.
    assign w_head_rec = w_head_word[FIFO_W-1:CYCLE_W];
    assign rec_valid  = !w_empty;
    assign rec_pc     = w_empty ? '0 : w_head_rec.pc;
    assign rec_reg    = w_empty ? '0 : w_head_rec.rd;
    assign rec_data   = w_empty ? '0 : w_head_rec.data;
    assign rec_cycle  = w_empty ? '0 : w_head_word[CYCLE_W-1:0];
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

    // Free-running timestamp, restarted by reset.
    always_ff @(posedge clk) begin
        if (rst) r_cycle <= '0;
        else     r_cycle <= r_cycle + CYCLE_W'(1);
    end

    // Sticky drop tracking with a saturating counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_commit_monitor.sv
// tb/tb_commit_monitor.sv - directed and randomized checks of commit_monitor against a queue model
module tb_commit_monitor;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        rec_ready;

    logic        rec_valid,  rec_valid4;
    logic [31:0] rec_pc,     rec_pc4;
    logic [4:0]  rec_reg,    rec_reg4;
    logic [31:0] rec_data,   rec_data4;
    logic [15:0] rec_cycle;
    logic [3:0]  rec_cycle4;
    logic [3:0]  fill,       fill4;
    logic        overflow,   overflow4;
    logic [7:0]  drop_count, drop_count4;

    always #5 clk = ~clk;

    commit_monitor #(.DEPTH(DEPTH), .CYCLE_W(16)) dut (
        .clk(clk), .rst(rst), .pc(pc), .reg_write(reg_write), .write_reg(write_reg),
        .write_data(write_data), .rec_ready(rec_ready), .rec_valid(rec_valid),
        .rec_pc(rec_pc), .rec_reg(rec_reg), .rec_data(rec_data), .rec_cycle(rec_cycle),
        .fill(fill), .overflow(overflow), .drop_count(drop_count)
    );

    commit_monitor #(.DEPTH(DEPTH), .CYCLE_W(4)) dut4 (
        .clk(clk), .rst(rst), .pc(pc), .reg_write(reg_write), .write_reg(write_reg),
        .write_data(write_data), .rec_ready(rec_ready), .rec_valid(rec_valid4),
        .rec_pc(rec_pc4), .rec_reg(rec_reg4), .rec_data(rec_data4), .rec_cycle(rec_cycle4),
        .fill(fill4), .overflow(overflow4), .drop_count(drop_count4)
    );

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } mrec_t;

    mrec_t m_q[$];
    int    m_cnt;
    bit    m_ovf;
    int    m_drops;
    int    n_vec;
    int    n_chk;
    int    n_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: a plain queue of records plus counters, advanced once per clock.
    task automatic model_step();
        bit    do_pop;
        bit    cap;
        int    sz;
        mrec_t r;
        if (rst) begin
            m_q.delete();
            m_ovf   = 0;
            m_drops = 0;
            m_cnt   = 0;
        end else begin
            sz     = m_q.size();
            do_pop = rec_ready && (sz > 0);
            cap    = reg_write && (write_reg != 5'd0);
            if (do_pop) void'(m_q.pop_front());
            if (cap) begin
                if (sz < DEPTH || do_pop) begin
                    r.pc = pc; r.rd = write_reg; r.data = write_data; r.cyc = m_cnt;
                    m_q.push_back(r);
                end else begin
                    m_ovf = 1;
                    if (m_drops < 255) m_drops++;
                end
            end
            m_cnt++;
        end
    endtask

    task automatic check_all();
        check("valid",      64'(rec_valid),  64'(m_q.size() > 0));
        check("fill",       64'(fill),       64'(m_q.size()));
        check("overflow",   64'(overflow),   64'(m_ovf));
        check("drop_count", 64'(drop_count), 64'(m_drops));
        check("fill4",      64'(fill4),      64'(m_q.size()));
        if (m_q.size() > 0) begin
            check("pc",     64'(rec_pc),     64'(m_q[0].pc));
            check("reg",    64'(rec_reg),    64'(m_q[0].rd));
            check("data",   64'(rec_data),   64'(m_q[0].data));
            check("cycle",  64'(rec_cycle),  64'(m_q[0].cyc % 65536));
            check("cycle4", 64'(rec_cycle4), 64'(m_q[0].cyc % 16));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        n_vec++;
        check_all();
    endtask

    task automatic idle();
        reg_write  = 1'b0;
        write_reg  = 5'd0;
        rec_ready  = 1'b0;
    endtask

    task automatic capture(input logic [31:0] p, input logic [4:0] rd, input logic [31:0] d);
        reg_write  = 1'b1;
        pc         = p;
        write_reg  = rd;
        write_data = d;
    endtask

    initial begin
        n_vec = 0; n_chk = 0; n_err = 0;
        m_cnt = 0; m_ovf = 0; m_drops = 0;
        rst = 1'b1; pc = '0; write_data = '0;
        idle();

        // Reset state
        tick(); tick();
        check("rst_pc",    64'(rec_pc),    64'd0);
        check("rst_reg",   64'(rec_reg),   64'd0);
        check("rst_data",  64'(rec_data),  64'd0);
        check("rst_cycle", 64'(rec_cycle), 64'd0);
        rst = 1'b0;

        // Single capture in cycle 3, popped immediately
        tick(); tick(); tick();
        capture(32'h4, 5'd16, 32'h5);
        rec_ready = 1'b1;
        tick();
        check("t1_valid", 64'(rec_valid), 64'd1);
        check("t1_pc",    64'(rec_pc),    64'h4);
        check("t1_reg",   64'(rec_reg),   64'd16);
        check("t1_data",  64'(rec_data),  64'h5);
        check("t1_cycle", 64'(rec_cycle), 64'd3);
        reg_write = 1'b0;
        tick();
        check("t1_fill", 64'(fill), 64'd0);

        // Writes to $zero are filtered
        rec_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            capture(32'h100 + 32'(i * 4), 5'd0, 32'hDEAD0000 + 32'(i));
            tick();
        end
        check("zero_valid", 64'(rec_valid), 64'd0);
        check("zero_fill",  64'(fill),      64'd0);

        // Overfill: 10 captures into 8 slots
        for (int i = 1; i <= 10; i++) begin
            capture(32'h200 + 32'(i * 4), 5'd8, 32'(i));
            tick();
        end
        check("of_fill",  64'(fill),       64'd8);
        check("of_ovf",   64'(overflow),   64'd1);
        check("of_drops", 64'(drop_count), 64'd2);
        check("of_head",  64'(rec_data),   64'd1);

        // Full with simultaneous capture and pop
        capture(32'h300, 5'd9, 32'hAA);
        rec_ready = 1'b1;
        tick();
        check("fp_fill",  64'(fill),       64'd8);
        check("fp_drops", 64'(drop_count), 64'd2);
        check("fp_head",  64'(rec_data),   64'd2);
        reg_write = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("fp_last", 64'(rec_data), 64'hAA);
        tick();
        check("fp_empty", 64'(rec_valid), 64'd0);

        // Reset mid-operation with 3 records queued
        rec_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            capture(32'h400, 5'd10, 32'(i + 50));
            tick();
        end
        reg_write = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rs_valid", 64'(rec_valid),  64'd0);
        check("rs_fill",  64'(fill),       64'd0);
        check("rs_ovf",   64'(overflow),   64'd0);
        check("rs_drops", 64'(drop_count), 64'd0);
        capture(32'h500, 5'd11, 32'h77);
        tick();
        check("rs_stamp", 64'(rec_cycle), 64'd0);

        // Timestamp wrap with a 4-bit counter
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        capture(32'h600, 5'd12, 32'h15);
        tick();
        capture(32'h604, 5'd13, 32'h16);
        tick();
        reg_write = 1'b0;
        tick();
        check("wrap_first", 64'(rec_cycle4), 64'd15);
        rec_ready = 1'b1;
        tick();
        check("wrap_second", 64'(rec_cycle4), 64'd0);
        check("wrap_wide",   64'(rec_cycle),  64'd16);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 59) == 0);
            reg_write  = ($urandom_range(0, 9) < 7);
            write_reg  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            write_data = $urandom;
            pc         = $urandom & 32'hFFFF_FFFC;
            rec_ready  = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
